// File: rtl/turn_arbiter_m_pkg.sv
// Shared types and encodings for the move-interface arbiter and its legality checker.
package turn_arbiter_m_pkg;

  typedef logic       flag_t;
  typedef logic [3:0] index_t;

  localparam flag_t TURN_PLAYER = 1'b0;
  localparam flag_t TURN_AI     = 1'b1;

  localparam int unsigned CELL_COUNT = 9;

  localparam logic [1:0] WINNER_NONE   = 2'b00;
  localparam logic [1:0] WINNER_PLAYER = 2'b01;
  localparam logic [1:0] WINNER_AI     = 2'b10;
  localparam logic [1:0] WINNER_DRAW   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CLEAR       = 3'd1,
    ST_PLAYER_WAIT = 3'd2,
    ST_AI_WAIT     = 3'd3,
    ST_COMMIT      = 3'd4,
    ST_CHECK       = 3'd5,
    ST_DONE        = 3'd6
  } state_t;

endpackage

// File: rtl/move_checker_m.sv
// Combinational move legality: cell index in range and not yet occupied.
module move_checker_m
  import turn_arbiter_m_pkg::*;
(
  input  logic [CELL_COUNT-1:0] mask,
  input  index_t                index,
  output logic                  legal
);

  logic [15:0] mask_ext;

  always_comb begin
    mask_ext = 16'(mask);
    legal    = (index < 4'(CELL_COUNT)) && !mask_ext[index];
  end

endmodule

// File: rtl/turn_arbiter_m.sv
// Registered sequencer sharing the board move interface between player and AI;
// owns the turn flag, rejects illegal moves, counts moves and declares the result.
module turn_arbiter_m
  import turn_arbiter_m_pkg::*;
#(
  parameter flag_t       FIRST_TURN = TURN_PLAYER,
  parameter int unsigned AI_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  index_t     player_update_loc,
  input  logic       player_submit,
  input  logic       player_reset,
  input  index_t     ai_update_loc,
  input  logic       ai_submit,
  input  logic       ai_reset,
  input  logic       board_win,
  output logic       turn,
  output index_t     board_update_loc,
  output logic       board_submit,
  output logic       board_reset,
  output logic       illegal,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned TW = (AI_TIMEOUT < 2) ? 1 : $clog2(AI_TIMEOUT + 1);

  state_t                state_q, state_d;
  flag_t                 turn_q, turn_d;
  logic [CELL_COUNT-1:0] mask_q, mask_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            winner_q, winner_d;
  index_t                loc_q, loc_d;
  logic                  bsub_q, bsub_d;
  logic                  brst_q, brst_d;
  logic                  ill_q, ill_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic                  in_ai_wait;
  index_t                sel_loc;
  logic                  sel_submit;
  logic                  sel_legal;
  logic                  go_clear;
  logic [TW-1:0]         tmo_inc;

  move_checker_m u_move_checker (
    .mask  (mask_q),
    .index (sel_loc),
    .legal (sel_legal)
  );

  always_comb begin
    in_ai_wait = (state_q == ST_AI_WAIT);
    sel_loc    = in_ai_wait ? ai_update_loc : player_update_loc;
    sel_submit = in_ai_wait ? ai_submit : player_submit;
    tmo_inc    = tmo_q + 1'b1;

    state_d  = state_q;
    turn_d   = turn_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    loc_d    = loc_q;
    bsub_d   = 1'b0;
    brst_d   = 1'b0;
    ill_d    = 1'b0;
    tmo_d    = tmo_q;
    go_clear = 1'b0;

    if ((player_reset || ai_reset) && (state_q != ST_IDLE)) begin
      go_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: go_clear = start;
        ST_CLEAR: begin
          state_d = (FIRST_TURN == TURN_AI) ? ST_AI_WAIT : ST_PLAYER_WAIT;
          tmo_d   = '0;
        end
        ST_PLAYER_WAIT, ST_AI_WAIT: begin
          if (sel_submit && sel_legal) begin
            state_d = ST_COMMIT;
            loc_d   = sel_loc;
            bsub_d  = 1'b1;
          end else begin
            ill_d = sel_submit;
            if (in_ai_wait && (AI_TIMEOUT != 0)) begin
              tmo_d = tmo_inc;
              if (tmo_inc == TW'(AI_TIMEOUT)) begin
                state_d  = ST_DONE;
                winner_d = WINNER_PLAYER;
              end
            end
          end
        end
        ST_COMMIT: begin
          state_d = ST_CHECK;
          mask_d  = mask_q | (CELL_COUNT'(1) << loc_q);
          cnt_d   = cnt_q + 4'd1;
        end
        ST_CHECK: begin
          if (board_win) begin
            state_d  = ST_DONE;
            winner_d = (turn_q == TURN_PLAYER) ? WINNER_PLAYER : WINNER_AI;
          end else if (cnt_q == 4'(CELL_COUNT)) begin
            state_d  = ST_DONE;
            winner_d = WINNER_DRAW;
          end else begin
            turn_d  = ~turn_q;
            state_d = (turn_q == TURN_PLAYER) ? ST_AI_WAIT : ST_PLAYER_WAIT;
            tmo_d   = '0;
          end
        end
        ST_DONE: go_clear = start;
        default: state_d = ST_IDLE;
      endcase
    end

    // A reset request while already clearing restarts CLEAR without a second board strobe.
    if (go_clear) begin
      state_d  = ST_CLEAR;
      brst_d   = (state_q != ST_CLEAR);
      turn_d   = FIRST_TURN;
      mask_d   = '0;
      cnt_d    = '0;
      winner_d = WINNER_NONE;
      tmo_d    = '0;
      bsub_d   = 1'b0;
      ill_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      turn_q   <= FIRST_TURN;
      mask_q   <= '0;
      cnt_q    <= '0;
      winner_q <= WINNER_NONE;
      loc_q    <= '0;
      bsub_q   <= 1'b0;
      brst_q   <= 1'b0;
      ill_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      loc_q    <= loc_d;
      bsub_q   <= bsub_d;
      brst_q   <= brst_d;
      ill_q    <= ill_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    turn             = turn_q;
    board_update_loc = loc_q;
    board_submit     = bsub_q;
    board_reset      = brst_q;
    illegal          = ill_q;
    move_count       = cnt_q;
    game_over        = (state_q == ST_DONE);
    winner           = winner_q;
  end

endmodule
